// File: rtl/param_lifo_pkg.sv
// Shared definitions for the FIFO/stack buffer family: default sizes and a
// constant-foldable clog2 used to derive counter and address widths.
package param_lifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Smallest r such that 2**r >= v (clog2(1) = 0).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/param_lifo_if.sv
// Handshake bundle between a stack user (master) and the stack (slave).
interface param_lifo_if
  import param_lifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = clog2(DEF_DEPTH + 1)
);

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, din,
    input  dout, dout_valid, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, din,
    output dout, dout_valid, count, full, empty, overflow, underflow
  );

endinterface

// File: rtl/param_lifo_mem.sv
// Stack storage: DEPTH x DATA_W register array with one write port and one
// registered read port. A read and a write to the same address in one cycle
// return the old word. The fwd input loads the read register straight from
// wdata, which the stack uses for its empty push+pop pass-through.
module lifo_mem
  import param_lifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = clog2(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  input  logic              fwd,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write; contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, holds its value when no read is requested.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= fwd ? wdata : mem[raddr];
  end

endmodule

// File: rtl/param_lifo.sv
// Parametrised LIFO stack. The occupancy count doubles as the stack pointer:
// writes go to count, reads come from count-1. Push and pop together replace
// the top entry (or pass din straight through when the stack is empty).
module param_lifo
  import param_lifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input logic       clk,
  input logic       rst,
  param_lifo_if.slave lifo
);

  localparam int CNT_W = clog2(DEPTH + 1);
  localparam int AW    = clog2(DEPTH);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [AW-1:0]    addr_t;

  cnt_t              count_q;
  logic              full_w;
  logic              empty_w;
  addr_t             top_addr;
  logic              we;
  addr_t             waddr;
  logic              re;
  logic              fwd;
  logic              inc;
  logic              dec;
  logic              ovf_d;
  logic              unf_d;
  logic              dout_valid_q;
  logic              overflow_q;
  logic              underflow_q;
  logic [DATA_W-1:0] dout_q;

  assign full_w   = (count_q == cnt_t'(DEPTH));
  assign empty_w  = (count_q == '0);
  assign top_addr = addr_t'(count_q - cnt_t'(1));

  // Decode the push/pop strobes against the current occupancy into memory
  // enables, count steps and error requests; reset suppresses everything.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    re    = 1'b0;
    fwd   = 1'b0;
    inc   = 1'b0;
    dec   = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (!rst) begin
      unique case ({lifo.push, lifo.pop})
        2'b10: begin
          if (full_w) begin
            ovf_d = 1'b1;
          end else begin
            we    = 1'b1;
            waddr = addr_t'(count_q);
            inc   = 1'b1;
          end
        end
        2'b01: begin
          if (empty_w) begin
            unf_d = 1'b1;
          end else begin
            re  = 1'b1;
            dec = 1'b1;
          end
        end
        2'b11: begin
          re = 1'b1;
          if (empty_w) begin
            fwd = 1'b1;
          end else begin
            we    = 1'b1;
            waddr = top_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // Occupancy register; the decode guards keep it within 0..DEPTH.
  always_ff @(posedge clk) begin
    if (rst)      count_q <= '0;
    else if (inc) count_q <= count_q + cnt_t'(1);
    else if (dec) count_q <= count_q - cnt_t'(1);
  end

  // Single-cycle status pulses for a completed read and rejected requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      dout_valid_q <= re;
      overflow_q   <= ovf_d;
      underflow_q  <= unf_d;
    end
  end

  lifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (lifo.din),
    .re    (re),
    .raddr (top_addr),
    .fwd   (fwd),
    .rdata (dout_q)
  );

  assign lifo.dout       = dout_q;
  assign lifo.dout_valid = dout_valid_q;
  assign lifo.count      = count_q;
  assign lifo.full       = full_w;
  assign lifo.empty      = empty_w;
  assign lifo.overflow   = overflow_q;
  assign lifo.underflow  = underflow_q;

endmodule

// File: tb/tb_param_lifo.sv
// Directed bench for param_lifo: a DEPTH=4/8-bit stack for the full set of
// scenarios and a DEPTH=5/16-bit stack for the non-power-of-two depth.
module tb_param_lifo;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  param_lifo_if #(.DATA_W(8),  .CNT_W(3)) if_a ();
  param_lifo_if #(.DATA_W(16), .CNT_W(3)) if_b ();

  param_lifo #(.DATA_W(8), .DEPTH(4)) dut_a (
    .clk  (clk),
    .rst  (rst),
    .lifo (if_a)
  );

  param_lifo #(.DATA_W(16), .DEPTH(5)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .lifo (if_b)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: [31:16] dout, [7] valid, [6] overflow, [5] underflow,
  // [4] full, [3] empty, [2:0] count.
  function automatic logic [31:0] mk(input logic [15:0] d, input logic v,
                                     input logic o, input logic u,
                                     input logic f, input logic e,
                                     input logic [2:0] c);
    return {d, 8'h00, v, o, u, f, e, c};
  endfunction

  function automatic logic [31:0] snap(input int sel);
    if (sel == 0)
      return {8'h00, if_a.dout, 8'h00, if_a.dout_valid, if_a.overflow,
              if_a.underflow, if_a.full, if_a.empty, if_a.count};
    return {if_b.dout, 8'h00, if_b.dout_valid, if_b.overflow,
            if_b.underflow, if_b.full, if_b.empty, if_b.count};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of strobes, let the edge happen, then sample 1 unit later.
  task automatic applyStimulus(input int sel, input logic p, input logic q,
                               input logic [15:0] d);
    if (sel == 0) begin
      if_a.push = p; if_a.pop = q; if_a.din = d[7:0];
    end else begin
      if_b.push = p; if_b.pop = q; if_b.din = d;
    end
    @(posedge clk);
    #1;
    if_a.push = 1'b0; if_a.pop = 1'b0;
    if_b.push = 1'b0; if_b.pop = 1'b0;
  endtask

  task automatic stepCheck(input int sel, input logic p, input logic q,
                           input logic [15:0] d, input string tag,
                           input logic [31:0] expected);
    applyStimulus(sel, p, q, d);
    checkOutput(tag, snap(sel), expected);
  endtask

  // Push 0x11..0x44 into the small stack and check the count climbing.
  task automatic fillA(input logic [15:0] hold_dout);
    logic [7:0] w;
    for (int i = 0; i < 4; i++) begin
      w = 8'(8'h11 * (i + 1));
      stepCheck(0, 1, 0, {8'h00, w}, "fillA",
                mk(hold_dout, 0, 0, 0, (i == 3), 0, 3'(i + 1)));
    end
  endtask

  // Pop the remaining 0x33,0x22,0x11 from a stack holding three words.
  task automatic drainThreeA();
    stepCheck(0, 0, 1, 0, "drain33", mk(16'h33, 1, 0, 0, 0, 0, 3'd2));
    stepCheck(0, 0, 1, 0, "drain22", mk(16'h22, 1, 0, 0, 0, 0, 3'd1));
    stepCheck(0, 0, 1, 0, "drain11", mk(16'h11, 1, 0, 0, 0, 1, 3'd0));
  endtask

  initial begin
    logic [15:0] w16;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    if_a.push = 1'b0; if_a.pop = 1'b0; if_a.din = '0;
    if_b.push = 1'b0; if_b.pop = 1'b0; if_b.din = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    checkOutput("resetA", snap(0), mk(16'h0, 0, 0, 0, 0, 1, 3'd0));
    checkOutput("resetB", snap(1), mk(16'h0, 0, 0, 0, 0, 1, 3'd0));

    // Fill, then pop everything back in reverse order.
    fillA(16'h0);
    stepCheck(0, 0, 1, 0, "pop44", mk(16'h44, 1, 0, 0, 0, 0, 3'd3));
    drainThreeA();

    // Underflow at empty: pulse for one cycle, dout holds.
    stepCheck(0, 0, 1, 0, "underflow", mk(16'h11, 0, 0, 1, 0, 1, 3'd0));
    stepCheck(0, 0, 0, 0, "unf_clear", mk(16'h11, 0, 0, 0, 0, 1, 3'd0));

    // Overflow at full: pulse for one cycle, contents untouched.
    fillA(16'h11);
    stepCheck(0, 1, 0, 16'h55, "overflow", mk(16'h11, 0, 1, 0, 1, 0, 3'd4));
    stepCheck(0, 0, 0, 0, "ovf_clear", mk(16'h11, 0, 0, 0, 1, 0, 3'd4));
    stepCheck(0, 0, 1, 0, "pop_after_ovf", mk(16'h44, 1, 0, 0, 0, 0, 3'd3));
    drainThreeA();

    // Replace while full: old top returned, no overflow.
    fillA(16'h11);
    stepCheck(0, 1, 1, 16'h77, "replace_full", mk(16'h44, 1, 0, 0, 1, 0, 3'd4));
    stepCheck(0, 0, 1, 0, "pop_replaced", mk(16'h77, 1, 0, 0, 0, 0, 3'd3));
    drainThreeA();

    // Replace on a partly filled stack.
    stepCheck(0, 1, 0, 16'h11, "push11", mk(16'h11, 0, 0, 0, 0, 0, 3'd1));
    stepCheck(0, 1, 0, 16'h22, "push22", mk(16'h11, 0, 0, 0, 0, 0, 3'd2));
    stepCheck(0, 1, 1, 16'h99, "replace", mk(16'h22, 1, 0, 0, 0, 0, 3'd2));
    stepCheck(0, 0, 1, 0, "pop99", mk(16'h99, 1, 0, 0, 0, 0, 3'd1));
    stepCheck(0, 0, 1, 0, "pop11", mk(16'h11, 1, 0, 0, 0, 1, 3'd0));

    // Push+pop on empty passes din straight through.
    stepCheck(0, 1, 1, 16'hA5, "bypass", mk(16'hA5, 1, 0, 0, 0, 1, 3'd0));

    // Reset wins over a simultaneous push and discards the stack.
    stepCheck(0, 1, 0, 16'h11, "pre_rst11", mk(16'hA5, 0, 0, 0, 0, 0, 3'd1));
    stepCheck(0, 1, 0, 16'h22, "pre_rst22", mk(16'hA5, 0, 0, 0, 0, 0, 3'd2));
    rst = 1'b1;
    stepCheck(0, 1, 0, 16'h33, "rst_push", mk(16'h00, 0, 0, 0, 0, 1, 3'd0));
    rst = 1'b0;
    stepCheck(0, 0, 1, 0, "pop_after_rst", mk(16'h00, 0, 0, 1, 0, 1, 3'd0));

    // Non-power-of-two depth, 16-bit data.
    for (int i = 0; i < 5; i++) begin
      w16 = 16'(16'h1111 * (i + 1));
      stepCheck(1, 1, 0, w16, "fillB",
                mk(16'h0, 0, 0, 0, (i == 4), 0, 3'(i + 1)));
    end
    stepCheck(1, 1, 0, 16'h6666, "overflowB", mk(16'h0, 0, 1, 0, 1, 0, 3'd5));
    for (int i = 4; i >= 0; i--) begin
      w16 = 16'(16'h1111 * (i + 1));
      stepCheck(1, 0, 1, 0, "popB", mk(w16, 1, 0, 0, 0, (i == 0), 3'(i)));
    end
    stepCheck(1, 0, 0, 0, "idleB", mk(16'h1111, 0, 0, 0, 0, 1, 3'd0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, failures);
    $finish;
  end

endmodule
